srq_line_serializer: RTL and testbench
======================================

# srq_line_serializer

Drain-side companion to the shift-register queue (SRQ) in the DRAM controller datapath. It pops one WIDTH-bit line at a time from the SRQ tail and emits the line as BEATS = WIDTH/BEAT_W narrower beats on a valid/ready stream toward the DRAM data path. Beats go out LSB-first. The block supports back-to-back lines with no bubble and keeps a wrapping count of completed lines.

## Interface

Parameters:
- WIDTH, 1024, SRQ line width in bits.
- BEAT_W, 128, output beat width in bits. WIDTH must be an integer multiple of BEAT_W; BEATS = WIDTH/BEAT_W ≥ 2.
- CNT_W, 16, width of the line counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- srq_out_valid  in  1  SRQ tail holds a valid line.
- srq_data_out  in  WIDTH  SRQ tail data, valid when srq_out_valid=1.
- srq_pop  out  1  one-cycle pop strobe to the SRQ. Combinational.
- drain_en  in  1  permits new pops. Does not abort a line in progress.
- beat_valid  out  1  beat_data is valid.
- beat_ready  in  1  downstream accepts the beat.
- beat_data  out  BEAT_W  current beat. Forced to 0 when beat_valid=0.
- beat_last  out  1  current beat is beat BEATS-1 of its line.
- beat_idx  out  clog2(BEATS)  index of the current beat.
- busy  out  1  a line is held (state SEND).
- line_count  out  CNT_W  number of completed lines, mod 2^CNT_W.

## Operation

- State machine: IDLE and SEND. Registers: line_buf[WIDTH], beat_cnt, line_count.
- Definitions:
  - take = srq_out_valid & drain_en.
  - fire = beat_valid & beat_ready.
  - end_line = fire & (beat_cnt == BEATS-1).
- srq_pop is asserted in either of two cases:
  - state is IDLE and take is 1;
  - state is SEND and end_line and take are both 1.
  - It is never asserted when srq_out_valid=0. This guarantees no pop on an empty SRQ.
- Load: on every cycle with srq_pop=1:
  - line_buf <= srq_data_out;
  - beat_cnt <= 0;
  - next state is SEND.
- IDLE: beat_valid=0, busy=0. The state stays IDLE while take=0.
- SEND:
  - beat_valid=1, busy=1.
  - beat_data = line_buf[beat_cnt*BEAT_W +: BEAT_W].
  - beat_idx = beat_cnt.
  - beat_last = (beat_cnt == BEATS-1).
- On fire with beat_cnt < BEATS-1: beat_cnt increments by 1.
- On end_line:
  - line_count increments by 1 and wraps to 0 at 2^CNT_W.
  - If take=1, the next line is loaded and the state stays SEND, giving zero bubble.
  - Otherwise, next state is IDLE.
- Stream hold: while beat_valid=1 and beat_ready=0, beat_data, beat_last and beat_idx stay stable and no state changes.
- drain_en only gates pops. Deasserting it mid-line lets the current line finish; the block then goes IDLE.
- The SRQ line is removed from the SRQ at pop time. A line is owned by this block from its pop cycle until its end_line.

## Timing

- Reset values, applied asynchronously and immediately on rst=1:
  - state IDLE, beat_cnt 0, line_count 0;
  - beat_valid 0, beat_data 0, beat_last 0, beat_idx 0, busy 0.
  - srq_pop is 0 while rst=1.
  - line_buf is not reset; it is masked by beat_valid.
- Latency: srq_pop is asserted in cycle N. Beat 0 is valid in cycle N+1. With beat_ready held at 1, beat BEATS-1 is valid in cycle N+BEATS.
- Throughput: one beat per cycle when beat_ready=1. Consecutive lines produce no idle cycle between them.
- line_count updates on the edge after end_line.
- Reset mid-line: the held line is discarded and not re-popped. After rst deasserts, output resumes only on a new take.
- srq_out_valid=1 with drain_en=0 produces no pop, and the SRQ contents are untouched.

## Test plan

WIDTH=1024, BEAT_W=128, BEATS=8 unless stated otherwise.

1. **Single line:** present one line with beat k = 0x1111..×(k+1) and beat_ready=1.
   - srq_pop for exactly 1 cycle.
   - 8 consecutive beats in order; beat_last only on beat_idx 7.
   - line_count=1, then return to IDLE with beat_valid=0.
2. **Back-to-back lines:** SRQ holds lines A then B, beat_ready=1.
   - 16 consecutive beat_valid cycles.
   - Second srq_pop coincides with A's beat 7.
   - B beat 0 appears the next cycle; line_count=2.
3. **Backpressure:** drop beat_ready for 3 cycles while beat_idx=3.
   - beat_data, beat_idx=3 and beat_last=0 are held for those cycles.
   - No srq_pop; the line completes 3 cycles later.
4. **drain_en gating:**
   - srq_out_valid=1 with drain_en=0 for 5 cycles gives no srq_pop and busy=0.
   - drain_en dropped at beat 2 of a line gives the remaining 6 beats, then IDLE with no further pop even though srq_out_valid=1.
5. **Reset mid-line:** assert rst during beat_idx=5.
   - beat_valid, busy and line_count read 0 in the same cycle.
   - After release, no beat until srq_out_valid rises, then a full 8-beat line.
6. **Counter wrap:** with CNT_W=4, stream 17 lines.
   - line_count reads 15 after line 15, 0 after line 16, 1 after line 17.

Source files
------------

// File: rtl/srq_line_serializer.sv
// srq_line_serializer
// Pops one WIDTH-bit line from the SRQ tail and replays it as BEATS
// LSB-first beats of BEAT_W bits on a valid/ready stream. Back-to-back
// lines are chained with no bubble. A wrapping counter tallies finished lines.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   srq_out_valid  SRQ tail holds a line
//   srq_data_out   SRQ tail line
//   srq_pop        combinational pop strobe to the SRQ
//   drain_en       permits new pops; a line in flight always completes
//   beat_valid     beat_data/beat_last/beat_idx are meaningful
//   beat_ready     downstream accepts the current beat
//   beat_data      current beat, zero while beat_valid=0
//   beat_last      current beat is the final beat of its line
//   beat_idx       index of the current beat within its line
//   busy           a line is held
//   line_count     completed lines, modulo 2^CNT_W
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no line held, waiting for a pop
// SEND  | line_buf holds a line, beat beat_cnt offered
module srq_line_serializer #(
  parameter int WIDTH  = 1024,
  parameter int BEAT_W = 128,
  parameter int CNT_W  = 16,
  localparam int BEATS = WIDTH / BEAT_W,
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              srq_out_valid,
  input  logic [WIDTH-1:0]  srq_data_out,
  output logic              srq_pop,
  input  logic              drain_en,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [BEAT_W-1:0] beat_data,
  output logic              beat_last,
  output logic [IDX_W-1:0]  beat_idx,
  output logic              busy,
  output logic [CNT_W-1:0]  line_count
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  line_buf;
  logic [IDX_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic              take, fire, at_last, end_line, load;
  logic [BEAT_W-1:0] beat_arr [BEATS];

  for (genvar g = 0; g < BEATS; g++) begin : g_beat
    assign beat_arr[g] = line_buf[g*BEAT_W +: BEAT_W];
  end

  assign take       = srq_out_valid & drain_en;
  assign beat_valid = (state == SEND);
  assign busy       = beat_valid;
  assign fire       = beat_valid & beat_ready;
  assign at_last    = (beat_cnt == LAST_IDX);
  assign end_line   = fire & at_last;

  assign beat_data = beat_valid ? beat_arr[beat_cnt] : '0;
  assign beat_idx  = beat_valid ? beat_cnt : '0;
  assign beat_last = beat_valid & at_last;

  // The strobe to the SRQ is suppressed during reset; the internal load
  // enable is left ungated because line_buf is masked by beat_valid anyway.
  assign srq_pop = load & ~rst;

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    load         = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          load         = 1'b1;
          beat_cnt_nxt = '0;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        if (end_line) begin
          beat_cnt_nxt = '0;
          if (take) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (fire) begin
          beat_cnt_nxt = beat_cnt + IDX_W'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      line_count <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (end_line) line_count <= line_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (load) line_buf <= srq_data_out;
  end

endmodule

// File: tb/tb_srq_line_serializer.sv
module tb_srq_line_serializer;

  localparam int WIDTH  = 1024;
  localparam int BEAT_W = 128;
  localparam int CNT_W  = 4;
  localparam int BEATS  = WIDTH / BEAT_W;

  logic              clk;
  logic              rst;
  logic              srq_out_valid;
  logic [WIDTH-1:0]  srq_data_out;
  logic              srq_pop;
  logic              drain_en;
  logic              beat_valid;
  logic              beat_ready;
  logic [BEAT_W-1:0] beat_data;
  logic              beat_last;
  logic [2:0]        beat_idx;
  logic              busy;
  logic [CNT_W-1:0]  line_count;

  srq_line_serializer #(.WIDTH(WIDTH), .BEAT_W(BEAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .srq_out_valid(srq_out_valid), .srq_data_out(srq_data_out), .srq_pop(srq_pop),
    .drain_en(drain_en),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
    .beat_last(beat_last), .beat_idx(beat_idx), .busy(busy), .line_count(line_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SRQ model: lines waiting in the queue, front is the tail.
  logic [WIDTH-1:0] srq_q[$];
  bit offer = 0;

  // Reference: the line currently owned and the position within it.
  bit               m_have = 0;
  int               m_k    = 0;
  logic [CNT_W-1:0] m_cnt  = '0;
  logic [WIDTH-1:0] m_line = '0;

  // Observation counters used by the directed tests.
  int pops = 0, vcnt = 0, pop_last = 0;
  logic [BEAT_W-1:0] obs_data[$];
  int                obs_idx[$];
  bit                obs_last[$];
  logic [CNT_W-1:0]  hist[$];
  logic [CNT_W-1:0]  prev_cnt = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit exp_pop_now();
    return !rst && srq_out_valid && drain_en &&
           (!m_have || (beat_ready && m_k == BEATS-1));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_have = 0;
      m_k    = 0;
      m_cnt  = '0;
    end else begin
      bit pop, done;
      pop  = srq_out_valid && drain_en && (!m_have || (beat_ready && m_k == BEATS-1));
      done = m_have && beat_ready && m_k == BEATS-1;
      if (m_have && beat_ready && m_k != BEATS-1) m_k++;
      if (done) m_cnt++;
      if (pop) begin
        m_line = srq_q.pop_front();
        m_have = 1;
        m_k    = 0;
      end else if (done) begin
        m_have = 0;
        m_k    = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("srq_pop",    {127'd0, srq_pop},    {127'd0, exp_pop_now()});
    chk("beat_valid", {127'd0, beat_valid}, {127'd0, m_have});
    chk("busy",       {127'd0, busy},       {127'd0, m_have});
    chk("beat_data",  beat_data,  m_have ? m_line[m_k*BEAT_W +: BEAT_W] : '0);
    chk("beat_last",  {127'd0, beat_last},  {127'd0, (m_have && m_k == BEATS-1)});
    chk("beat_idx",   {125'd0, beat_idx},   m_have ? 128'(m_k) : 128'd0);
    chk("line_count", {124'd0, line_count}, {124'd0, m_cnt});
    if (srq_pop) pops++;
    if (beat_valid) vcnt++;
    if (srq_pop && beat_valid && beat_last) pop_last++;
    if (beat_valid && beat_ready) begin
      obs_data.push_back(beat_data);
      obs_idx.push_back(int'(beat_idx));
      obs_last.push_back(beat_last);
    end
    if (line_count !== prev_cnt) begin
      hist.push_back(line_count);
      prev_cnt = line_count;
    end
  end

  task automatic drive_srq();
    srq_out_valid = offer && (srq_q.size() != 0);
    srq_data_out  = srq_out_valid ? srq_q[0] : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_srq();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_obs();
    pops = 0; vcnt = 0; pop_last = 0;
    obs_data.delete(); obs_idx.delete(); obs_last.delete();
  endtask

  task automatic wait_idx(input int idx);
    for (int n = 0; n < 40; n++) begin
      if (beat_valid && int'(beat_idx) == idx) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL wait_idx%0d actual=timeout required=beat_idx %0d", idx, idx);
  endtask

  function automatic logic [WIDTH-1:0] pattern_line();
    logic [WIDTH-1:0] l;
    logic [3:0] nib;
    for (int k = 0; k < BEATS; k++) begin
      nib = 4'(k + 1);
      l[k*BEAT_W +: BEAT_W] = {32{nib}};
    end
    return l;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_line();
    logic [WIDTH-1:0] l;
    for (int i = 0; i < WIDTH/32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_srq();
  endtask

  initial begin
    logic [3:0] nib;
    logic [BEAT_W-1:0] held;
    rst = 1'b1; drain_en = 1'b0; beat_ready = 1'b0; offer = 0;
    drive_srq();
    #2;
    chk("rst_beat_valid", {127'd0, beat_valid}, 128'd0);
    chk("rst_line_count", {124'd0, line_count}, 128'd0);
    chk("rst_srq_pop",    {127'd0, srq_pop},    128'd0);
    run(2);
    rst = 1'b0;
    run(1);

    // 1: single patterned line
    clear_obs();
    srq_q.push_back(pattern_line());
    offer = 1; drain_en = 1; beat_ready = 1;
    drive_srq();
    run(12);
    chk("t1_pops", 128'(pops), 128'd1);
    chk("t1_beats", 128'(obs_data.size()), 128'd8);
    for (int k = 0; k < obs_data.size() && k < BEATS; k++) begin
      nib = 4'(k + 1);
      chk($sformatf("t1_beat%0d", k), obs_data[k], {32{nib}});
      chk($sformatf("t1_idx%0d", k), 128'(obs_idx[k]), 128'(k));
      chk($sformatf("t1_last%0d", k), {127'd0, obs_last[k]}, {127'd0, (k == 7)});
    end
    chk("t1_line_count", {124'd0, line_count}, 128'd1);
    chk("t1_idle", {127'd0, beat_valid}, 128'd0);

    // 2: back-to-back lines
    clear_obs();
    srq_q.push_back(rnd_line());
    srq_q.push_back(rnd_line());
    drive_srq();
    run(20);
    chk("t2_valid_cycles", 128'(vcnt), 128'd16);
    chk("t2_pops", 128'(pops), 128'd2);
    chk("t2_pop_on_last", 128'(pop_last), 128'd1);
    chk("t2_line_count", {124'd0, line_count}, 128'd3);

    // 3: backpressure at beat 3
    clear_obs();
    srq_q.push_back(pattern_line());
    drive_srq();
    wait_idx(3);
    beat_ready = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      held = {32{4'h4}};
      chk("t3_hold_data", beat_data, held);
      chk("t3_hold_idx", {125'd0, beat_idx}, 128'd3);
      chk("t3_hold_last", {127'd0, beat_last}, 128'd0);
    end
    beat_ready = 1;
    run(8);
    chk("t3_pops", 128'(pops), 128'd1);
    chk("t3_beats", 128'(obs_data.size()), 128'd8);
    chk("t3_line_count", {124'd0, line_count}, 128'd4);

    // 4: drain_en gating
    clear_obs();
    drain_en = 0;
    srq_q.push_back(rnd_line());
    srq_q.push_back(rnd_line());
    drive_srq();
    run(5);
    chk("t4_no_pop", 128'(pops), 128'd0);
    chk("t4_busy", {127'd0, busy}, 128'd0);
    drain_en = 1;
    wait_idx(2);
    drain_en = 0;
    run(12);
    chk("t4_pops", 128'(pops), 128'd1);
    chk("t4_beats", 128'(obs_data.size()), 128'd8);
    chk("t4_idle", {127'd0, busy}, 128'd0);
    chk("t4_queue_left", 128'(srq_q.size()), 128'd1);
    srq_q.delete();
    drain_en = 1;
    drive_srq();

    // 5: reset mid-line
    srq_q.push_back(rnd_line());
    drive_srq();
    wait_idx(5);
    rst = 1;
    #1;
    chk("t5_valid", {127'd0, beat_valid}, 128'd0);
    chk("t5_busy", {127'd0, busy}, 128'd0);
    chk("t5_count", {124'd0, line_count}, 128'd0);
    tick();
    rst = 0;
    offer = 0;
    clear_obs();
    srq_q.push_back(rnd_line());
    drive_srq();
    run(5);
    chk("t5_quiet", 128'(vcnt), 128'd0);
    offer = 1;
    drive_srq();
    run(12);
    chk("t5_beats", 128'(obs_data.size()), 128'd8);

    // 6: counter wrap with CNT_W=4
    pulse_rst();
    hist.delete();
    prev_cnt = '0;
    for (int i = 0; i < 17; i++) srq_q.push_back(rnd_line());
    drive_srq();
    run(17*BEATS + 10);
    chk("t6_changes", 128'(hist.size()), 128'd17);
    if (hist.size() >= 17) begin
      chk("t6_after15", {124'd0, hist[14]}, 128'd15);
      chk("t6_after16", {124'd0, hist[15]}, 128'd0);
      chk("t6_after17", {124'd0, hist[16]}, 128'd1);
    end

    // Randomized traffic against the reference
    for (int c = 0; c < 3000; c++) begin
      beat_ready = ($urandom_range(0, 3) != 0);
      drain_en   = ($urandom_range(0, 7) != 0);
      offer      = ($urandom_range(0, 5) != 0);
      if (srq_q.size() < 3 && $urandom_range(0, 2) == 0) srq_q.push_back(rnd_line());
      drive_srq();
      if ($urandom_range(0, 499) == 0) begin
        rst = 1;
        tick();
        rst = 0;
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
